fll_float_decode: RTL and testbench



---
 rtl/fll_float_decode.sv | 114 +++++++++++
 tb/tb_fll_float_decode.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fll_float_decode.sv
// Expands a compressed FLL discriminator sample (leading-one exponent, truncated
// mantissa, sign) back into a two's-complement fixed-point value for the loop
// filter. Two-stage pipeline: stage 1 classifies the exponent, stage 2 shifts,
// saturates and negates. A sticky flag records format errors on valid samples.
module fll_float_decode #(
    parameter int unsigned MANT_W = 8,
    parameter int unsigned MAG_W  = 18,
    parameter int unsigned EXP_W  = 5,
    parameter bit          ROUND  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [EXP_W-1:0]   exp_in,
    input  logic [MANT_W-1:0]  mant_in,
    input  logic               sign_in,
    input  logic               err_clr,
    output logic               valid_out,
    output logic [MAG_W:0]     out,
    output logic               sat,
    output logic               err_sticky
);

    localparam logic [EXP_W-1:0] MinExp = EXP_W'(MANT_W - 1);
    localparam logic [EXP_W-1:0] MaxExp = EXP_W'(MAG_W - 1);

    // Stage 1 state
    logic              v1_q;
    logic [MANT_W-1:0] mant1_q;
    logic              sign1_q;
    logic [EXP_W-1:0]  shift1_q;
    logic              high1_q;
    logic              err1_q;

    // Stage 1 next-state
    logic              exp_low;
    logic              exp_high;
    logic [EXP_W-1:0]  shift_d;
    logic              err_d;

    // Stage 2 datapath
    logic [MAG_W:0]    shifted;
    logic [MAG_W-1:0]  mag;
    logic [MAG_W:0]    mag_ext;
    logic [MAG_W:0]    out_d;
    logic              err_next;

    // Classify the exponent and derive the shift amount and format error
    always_comb begin
        exp_low  = exp_in < MinExp;
        exp_high = exp_in > MaxExp;
        shift_d  = '0;
        if (!exp_low && !exp_high) begin
            shift_d = exp_in - MinExp;
        end
        // Above the minimum exponent the mantissa MSB must hold the leading one
        err_d = exp_low | exp_high | ((exp_in > MinExp) & ~mant_in[MANT_W-1]);
    end

    // Stage 1 register; payload only captured for valid samples
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q     <= 1'b0;
            mant1_q  <= '0;
            sign1_q  <= 1'b0;
            shift1_q <= '0;
            high1_q  <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            v1_q <= valid_in;
            if (valid_in) begin
                mant1_q  <= mant_in;
                sign1_q  <= sign_in;
                shift1_q <= shift_d;
                high1_q  <= exp_high;
                err1_q   <= err_d;
            end
        end
    end

    // Expand, saturate, negate; sticky error with set taking priority over clear
    always_comb begin
        // The extra low bit carries the half-LSB; it falls off again at shift 0
        shifted  = (MAG_W + 1)'({mant1_q, ROUND}) << shift1_q;
        mag      = high1_q ? '1 : shifted[MAG_W:1];
        mag_ext  = {1'b0, mag};
        out_d    = sign1_q ? -mag_ext : mag_ext;
        err_next = err_sticky;
        if (err_clr) begin
            err_next = 1'b0;
        end
        if (v1_q && err1_q) begin
            err_next = 1'b1;
        end
    end

    // Stage 2 register; out and sat hold while no valid sample arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out  <= 1'b0;
            out        <= '0;
            sat        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            valid_out  <= v1_q;
            err_sticky <= err_next;
            if (v1_q) begin
                out <= out_d;
                sat <= high1_q;
            end
        end
    end

endmodule

// File: tb/tb_fll_float_decode.sv
// Bench for fll_float_decode: two instances (ROUND=0 and ROUND=1) share stimulus;
// expected outputs are queued with their due cycle and checked as they emerge.
module tb_fll_float_decode;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [4:0]  exp_in;
    logic [7:0]  mant_in;
    logic        sign_in;
    logic        err_clr;

    logic        vo0, vo1, sat0, sat1, err0, err1;
    logic [18:0] out0, out1;

    typedef struct {
        int          due;
        logic [18:0] out;
        logic        sat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests  = 0;
    int   errors = 0;
    int   cyc    = 0;

    fll_float_decode #(.MANT_W(8), .MAG_W(18), .EXP_W(5), .ROUND(1'b0)) dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .exp_in(exp_in),
        .mant_in(mant_in), .sign_in(sign_in), .err_clr(err_clr),
        .valid_out(vo0), .out(out0), .sat(sat0), .err_sticky(err0)
    );

    fll_float_decode #(.MANT_W(8), .MAG_W(18), .EXP_W(5), .ROUND(1'b1)) dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .exp_in(exp_in),
        .mant_in(mant_in), .sign_in(sign_in), .err_clr(err_clr),
        .valid_out(vo1), .out(out1), .sat(sat1), .err_sticky(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference decode: returns {sat, out}
    function automatic logic [19:0] model(input int e, input int m, input int s, input int rnd);
        longint mag;
        longint o;
        int     sh;
        logic   st;
        if (e > 17) begin
            mag = (64'd1 << 18) - 1;
            st  = 1'b1;
        end else begin
            sh  = (e < 7) ? 0 : e - 7;
            mag = longint'(m) << sh;
            if (rnd != 0 && sh > 0) mag = mag | (64'd1 << (sh - 1));
            st  = 1'b0;
        end
        o = (s != 0) ? (((64'd1 << 19) - mag) & 64'h7FFFF) : mag;
        return {st, o[18:0]};
    endfunction

    // Scoreboard: compare each DUT's output stream against its queue
    always @(posedge clk) begin
        #1;
        if (vo0) begin
            if (q0.size() == 0 || q0[0].due != cyc) begin
                tests++; errors++;
                $display("FAIL r0_unexpected_valid cyc=%0d got valid_out=1 required 0", cyc);
            end else begin
                tests++;
                if (out0 !== q0[0].out) begin
                    errors++;
                    $display("FAIL r0_out cyc=%0d got %h required %h", cyc, out0, q0[0].out);
                end
                tests++;
                if (sat0 !== q0[0].sat) begin
                    errors++;
                    $display("FAIL r0_sat cyc=%0d got %b required %b", cyc, sat0, q0[0].sat);
                end
                void'(q0.pop_front());
            end
        end else if (q0.size() > 0 && q0[0].due <= cyc) begin
            tests++; errors++;
            $display("FAIL r0_missing_valid cyc=%0d got valid_out=0 required 1", cyc);
            void'(q0.pop_front());
        end
        if (vo1) begin
            if (q1.size() == 0 || q1[0].due != cyc) begin
                tests++; errors++;
                $display("FAIL r1_unexpected_valid cyc=%0d got valid_out=1 required 0", cyc);
            end else begin
                tests++;
                if (out1 !== q1[0].out) begin
                    errors++;
                    $display("FAIL r1_out cyc=%0d got %h required %h", cyc, out1, q1[0].out);
                end
                tests++;
                if (sat1 !== q1[0].sat) begin
                    errors++;
                    $display("FAIL r1_sat cyc=%0d got %b required %b", cyc, sat1, q1[0].sat);
                end
                void'(q1.pop_front());
            end
        end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            tests++; errors++;
            $display("FAIL r1_missing_valid cyc=%0d got valid_out=0 required 1", cyc);
            void'(q1.pop_front());
        end
    end

    // Apply one cycle of input at the negedge; queue expectations for valid samples
    task automatic drive(input logic v, input logic [4:0] e, input logic [7:0] m,
                         input logic s);
        logic [19:0] r;
        exp_t        x;
        valid_in = v;
        exp_in   = e;
        mant_in  = m;
        sign_in  = s;
        if (v) begin
            r = model(int'(e), int'(m), int'(s), 0);
            x.due = cyc + 2; x.out = r[18:0]; x.sat = r[19];
            q0.push_back(x);
            r = model(int'(e), int'(m), int'(s), 1);
            x.due = cyc + 2; x.out = r[18:0]; x.sat = r[19];
            q1.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (vo0 !== 1'b0 || vo1 !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b%b required 00", vo0, vo1);
        end
        tests++;
        if (out0 !== 19'h0 || out1 !== 19'h0) begin
            errors++; $display("FAIL reset_out got %h/%h required 0", out0, out1);
        end
        tests++;
        if (sat0 !== 1'b0 || sat1 !== 1'b0) begin
            errors++; $display("FAIL reset_sat got %b%b required 00", sat0, sat1);
        end
        tests++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b%b required 00", err0, err1);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        drive(1'b1, 5'd17, 8'hFF, 1'b0);
        idle(1);
        tests++;
        if (out0 !== 19'h3FC00) begin
            errors++; $display("FAIL basic_out got %h required 3fc00", out0);
        end
        tests++;
        if (err0 !== 1'b0) begin
            errors++; $display("FAIL basic_err got %b required 0", err0);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd7, 8'h5A, 1'b0);
        drive(1'b1, 5'd9, 8'hC0, 1'b1);
        drive(1'b1, 5'd12, 8'h80, 1'b0);
        drive(1'b1, 5'd7, 8'h01, 1'b0);
        drive(1'b1, 5'd17, 8'h80, 1'b1);
        idle(1);
        idle(2);
        tests++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++; $display("FAIL b2b_err got %b%b required 00", err0, err1);
        end
    endtask

    task automatic test_error();
        drive(1'b1, 5'd20, 8'h80, 1'b1);
        idle(1);
        tests++;
        if (err0 !== 1'b1 || err1 !== 1'b1) begin
            errors++; $display("FAIL err_high_set got %b%b required 11", err0, err1);
        end
        // Non-normalized sample; clear lands on the same edge as its set
        drive(1'b1, 5'd10, 8'h40, 1'b0);
        err_clr = 1'b1;
        idle(1);
        tests++;
        if (err0 !== 1'b1 || err1 !== 1'b1) begin
            errors++; $display("FAIL err_set_wins got %b%b required 11", err0, err1);
        end
        idle(1);
        tests++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b%b required 00", err0, err1);
        end
        err_clr = 1'b0;
        drive(1'b1, 5'd18, 8'h80, 1'b0);
        idle(1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    task automatic test_boundary();
        drive(1'b1, 5'd4, 8'h33, 1'b0);
        idle(1);
        tests++;
        if (err0 !== 1'b1) begin
            errors++; $display("FAIL low_exp_err got %b required 1", err0);
        end
        err_clr = 1'b1;
        exp_in  = 5'd31;
        idle(1);
        err_clr = 1'b0;
        idle(3);
        tests++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++; $display("FAIL invalid_no_err got %b%b required 00", err0, err1);
        end
        tests++;
        if (out0 !== 19'h00033 || sat0 !== 1'b0 || vo0 !== 1'b0) begin
            errors++;
            $display("FAIL hold_out got out=%h sat=%b v=%b required 00033/0/0", out0, sat0, vo0);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 5'd8, 8'h90, 1'b0);
        drive(1'b1, 5'd11, 8'hA5, 1'b1);
        // Third sample arrives together with reset; everything still in flight is lost
        reset    = 1'b1;
        valid_in = 1'b1;
        exp_in   = 5'd13;
        mant_in  = 8'hF0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b0;
        tests++;
        if (vo0 !== 1'b0 || vo1 !== 1'b0 || out0 !== 19'h0 || out1 !== 19'h0) begin
            errors++;
            $display("FAIL midreset_clear got v=%b%b out=%h/%h required 00 0/0",
                     vo0, vo1, out0, out1);
        end
        idle(3);
        drive(1'b1, 5'd14, 8'hC3, 1'b1);
        idle(4);
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending required 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        exp_in   = '0;
        mant_in  = '0;
        sign_in  = 1'b0;
        err_clr  = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_error();
        test_boundary();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
